i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 The module SHALL have no parameters; all widths and constants SHALL come from audioport_pkg.
REQ-002 clk  input  1  the single system clock; all logic SHALL be on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 sck_in  input  1  I2S serial bit clock, synchronous to clk, high and low for at least 1 clk cycle each (8 clk per bit at MCLK_DIV_48000).
REQ-005 ws_in  input  1  I2S word select: 0 = left, 1 = right.
REQ-006 sdo_in  input  1  I2S serial data, MSB first.
REQ-007 audio_out  output  48  last complete frame, {left[23:0], right[23:0]}.
REQ-008 audio_valid_out  output  1  one-clk pulse when audio_out is updated.
REQ-009 frame_error_out  output  1  one-clk pulse on framing violation.
REQ-010 synced_out  output  1  high while locked to frame timing.

Function
REQ-011 sck_in SHALL be registered once; a bit event SHALL be the clk edge where sck_in=1 and the registered copy=0.
REQ-012 At each bit event, sdo_in and ws_in SHALL be sampled; ws_d SHALL hold ws_in from the previous bit event.
REQ-013 I2S timing: ws leads data by one bit; the bit sampled at an event where ws_in != ws_d is the LSB of the ws_d channel.
REQ-014 Word length SHALL be exactly I2S_SAMPLE_WIDTH = 24 bits; a frame SHALL be 48 bits.
REQ-015 FSM states: WAIT_SYNC, RX_LEFT, RX_RIGHT; a 5-bit bit counter SHALL count bits of the current word.
REQ-016 WAIT_SYNC: on a bit event with ws_d=1, ws_in=0 -> RX_LEFT, counter=0; all other events are ignored.
REQ-017 RX_LEFT/RX_RIGHT: each bit event SHALL shift sdo_in into the channel shift register (LSB in) and increment the counter.
REQ-018 RX_LEFT, bit event with ws_in=1 and counter=23: latch left word incl. this bit, counter=0 -> RX_RIGHT.
REQ-019 RX_RIGHT, bit event with ws_in=0 and counter=23: audio_out <= {left, right incl. this bit}, audio_valid_out pulses, counter=0 -> RX_LEFT.
REQ-020 audio_out and audio_valid_out SHALL be registered, visible in the clk cycle after the completing bit event (latency 1 clk from detection).
REQ-021 Error: ws transition with counter != 23, or bit event with counter=23 and no transition (25th bit) -> frame_error_out pulse, -> WAIT_SYNC, no audio_valid_out.
REQ-022 After an error, lock SHALL resume only at the next 1->0 ws transition, even if the error event itself was one.
REQ-023 audio_out SHALL hold its last value across errors and WAIT_SYNC.
REQ-024 synced_out SHALL be 1 exactly when state != WAIT_SYNC (registered state decode).
REQ-025 audio_valid_out and frame_error_out SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force state=WAIT_SYNC, counter=0, shift registers=0, ws_d=0, sck register=0, audio_out=0, audio_valid_out=0, frame_error_out=0, synced_out=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no valid or error pulse SHALL result from it.

Structure
REQ-028 audioport_pkg SHALL gain I2S_SAMPLE_WIDTH=24, I2S_FRAME_BITS=48 and typedef enum i2s_rx_state_t {WAIT_SYNC, RX_LEFT, RX_RIGHT}.
REQ-029 The block SHALL be a single module with no sub-modules; edge detection is inline.

Verification
REQ-030 After reset, sck period 8 clk, send frame L=24'h123456, R=24'hABCDEF preceded by one ws 1->0 transition -> one audio_valid_out pulse, audio_out=48'h123456ABCDEF, synced_out=1.
REQ-031 Stream 4 back-to-back frames (L=24'h000001,24'h800000,24'hFFFFFF,24'h7FFFFF; R=bitwise inverse) -> 4 pulses, exactly 48 bit events apart, correct values, no error.
REQ-032 Left word of 23 bits -> frame_error_out pulse at the short transition, synced_out=0, audio_out unchanged; next clean frame after a 1->0 transition reported correctly.
REQ-033 ws held constant for 30 bits after lock -> frame_error_out at 25th bit, synced_out=0, no audio_valid_out.
REQ-034 rst_n asserted mid right word, then released -> all outputs 0 immediately, first valid only after a new 1->0 transition and full frame.
REQ-035 Minimum sck timing (1 clk high, 1 clk low) with random data, checked against a reference model -> every frame matches, no errors.

Source files
------------

// File: rtl/audioport_pkg.sv
// Shared constants and types for the audio port blocks.
package audioport_pkg;

  localparam int unsigned I2S_SAMPLE_WIDTH = 24;
  localparam int unsigned I2S_FRAME_BITS   = 2 * I2S_SAMPLE_WIDTH;
  // Wide enough to count 0..I2S_SAMPLE_WIDTH-1
  localparam int unsigned I2S_CNT_WIDTH    = 5;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    RX_LEFT,
    RX_RIGHT
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_receiver.sv
// I2S receiver: locks to the word-select frame timing, deserialises 24-bit left/right
// words and presents complete stereo frames with a one-clock valid pulse.
module i2s_receiver
  import audioport_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sck_in,
  input  logic                      ws_in,
  input  logic                      sdo_in,
  output logic [I2S_FRAME_BITS-1:0] audio_out,
  output logic                      audio_valid_out,
  output logic                      frame_error_out,
  output logic                      synced_out
);

  localparam int unsigned W = I2S_SAMPLE_WIDTH;
  localparam logic [I2S_CNT_WIDTH-1:0] LastBit = I2S_CNT_WIDTH'(W - 1);

  i2s_rx_state_t             state_q, state_d;
  logic [I2S_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [W-1:0]              left_sr_q, left_sr_d;
  logic [W-1:0]              right_sr_q, right_sr_d;
  logic [I2S_FRAME_BITS-1:0] audio_q, audio_d;
  logic                      valid_q, valid_d;
  logic                      error_q, error_d;
  logic                      synced_q, synced_d;
  logic                      sck_q;
  // ws_in as sampled at the previous bit event
  logic                      ws_d_q, ws_d_d;

  logic bit_event;
  logic ws_edge;
  logic last_bit;

  assign bit_event = sck_in & ~sck_q;
  assign ws_edge   = ws_in != ws_d_q;
  assign last_bit  = cnt_q == LastBit;

  // Frame-tracking FSM, deserialisers and output next-state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    ws_d_d     = ws_d_q;

    if (bit_event) begin
      ws_d_d = ws_in;
      unique case (state_q)
        WAIT_SYNC: begin
          // A 1->0 ws edge marks the right LSB; the next bit is the left MSB
          if (ws_d_q && !ws_in) begin
            state_d = RX_LEFT;
            cnt_d   = '0;
          end
        end
        RX_LEFT: begin
          left_sr_d = {left_sr_q[W-2:0], sdo_in};
          cnt_d     = cnt_q + 1'b1;
          if (ws_edge && ws_in && last_bit) begin
            state_d = RX_RIGHT;
            cnt_d   = '0;
          end else if (ws_edge || last_bit) begin
            // Early ws edge, or a word that would run past 24 bits
            error_d = 1'b1;
            state_d = WAIT_SYNC;
            cnt_d   = '0;
          end
        end
        RX_RIGHT: begin
          right_sr_d = {right_sr_q[W-2:0], sdo_in};
          cnt_d      = cnt_q + 1'b1;
          if (ws_edge && !ws_in && last_bit) begin
            audio_d = {left_sr_q, right_sr_q[W-2:0], sdo_in};
            valid_d = 1'b1;
            state_d = RX_LEFT;
            cnt_d   = '0;
          end else if (ws_edge || last_bit) begin
            error_d = 1'b1;
            state_d = WAIT_SYNC;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = WAIT_SYNC;
          cnt_d   = '0;
        end
      endcase
    end

    synced_d = state_d != WAIT_SYNC;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_SYNC;
      cnt_q      <= '0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      synced_q   <= 1'b0;
      sck_q      <= 1'b0;
      ws_d_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      synced_q   <= synced_d;
      sck_q      <= sck_in;
      ws_d_q     <= ws_d_d;
    end
  end

  assign audio_out       = audio_q;
  assign audio_valid_out = valid_q;
  assign frame_error_out = error_q;
  assign synced_out      = synced_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver with an expected-frame scoreboard.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck_in;
  logic        ws_in;
  logic        sdo_in;
  logic [47:0] audio_out;
  logic        audio_valid_out;
  logic        frame_error_out;
  logic        synced_out;

  i2s_receiver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sck_in          (sck_in),
    .ws_in           (ws_in),
    .sdo_in          (sdo_in),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .frame_error_out (frame_error_out),
    .synced_out      (synced_out)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  int          n_err    = 0;
  int          bit_cnt  = 0;
  int          hi       = 4;
  int          lo       = 4;
  logic [47:0] exp_q[$];
  int          valid_bits[$];
  int          err_bits[$];
  logic [47:0] exp_frame;

  int          start;
  int          eb;
  int          v0;
  int          e0;
  logic [23:0] lw;
  logic [23:0] rw;
  logic [23:0] vec[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit slot: data and ws change with the rising sck edge
  task automatic send_bit(input logic ws, input logic sd);
    ws_in  = ws;
    sdo_in = sd;
    sck_in = 1'b1;
    bit_cnt++;
    repeat (hi) @(posedge clk);
    #1 sck_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  // MSB..bit1 under the word's channel, LSB under the next channel
  task automatic send_word(input logic ch, input logic [23:0] w);
    for (int i = 23; i >= 1; i--) send_bit(ch, w[i]);
    send_bit(~ch, w[0]);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_word(1'b0, l);
    send_word(1'b1, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every valid pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (audio_valid_out) begin
        n_valid++;
        valid_bits.push_back(bit_cnt);
        n_checks++;
        assert (exp_q.size() > 0)
        else begin
          n_fail++;
          $error("FAIL sb_empty: unexpected frame %h, expected none", audio_out);
        end
        if (exp_q.size() > 0) begin
          exp_frame = exp_q.pop_front();
          n_checks++;
          assert (audio_out === exp_frame)
          else begin
            n_fail++;
            $error("FAIL sb_frame: observed %h expected %h", audio_out, exp_frame);
          end
        end
      end
      if (frame_error_out) begin
        n_err++;
        err_bits.push_back(bit_cnt);
      end
      if (audio_valid_out || frame_error_out) begin
        n_checks++;
        assert (!(audio_valid_out && frame_error_out))
        else begin
          n_fail++;
          $error("FAIL excl: observed valid=1 error=1 expected not both");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    sck_in = 1'b0;
    ws_in  = 1'b0;
    sdo_in = 1'b0;
    idle(3);
    chk("rst_audio", 64'(audio_out), 64'h0);
    chk("rst_valid", 64'(audio_valid_out), 64'h0);
    chk("rst_error", 64'(frame_error_out), 64'h0);
    chk("rst_synced", 64'(synced_out), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // Single frame after one ws 1->0 transition
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    start = bit_cnt;
    chk("lock_synced", 64'(synced_out), 64'h1);
    exp_q.push_back(48'h123456ABCDEF);
    send_frame(24'h123456, 24'hABCDEF);
    idle(4);
    chk("f1_count", 64'(n_valid), 64'd1);
    chk("f1_audio", 64'(audio_out), 64'h123456ABCDEF);
    chk("f1_bitpos", 64'(valid_bits[0]), 64'(start + 48));
    chk("f1_synced", 64'(synced_out), 64'h1);
    chk("f1_noerr", 64'(n_err), 64'd0);

    // Four back-to-back frames
    vec[0] = 24'h000001;
    vec[1] = 24'h800000;
    vec[2] = 24'hFFFFFF;
    vec[3] = 24'h7FFFFF;
    valid_bits.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({vec[i], ~vec[i]});
    for (int i = 0; i < 4; i++) send_frame(vec[i], ~vec[i]);
    idle(4);
    chk("b2b_count", 64'(n_valid), 64'd5);
    chk("b2b_nbits", 64'(valid_bits.size()), 64'd4);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", 64'(valid_bits[i] - valid_bits[i-1]), 64'd48);
    chk("b2b_noerr", 64'(n_err), 64'd0);

    // Short (23-bit) left word
    for (int i = 0; i < 22; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    eb = bit_cnt;
    idle(2);
    chk("short_err", 64'(n_err), 64'd1);
    chk("short_errpos", 64'(err_bits[$]), 64'(eb));
    chk("short_synced", 64'(synced_out), 64'h0);
    chk("short_hold", 64'(audio_out), 64'h7FFFFF800000);
    chk("short_novalid", 64'(n_valid), 64'd5);
    send_word(1'b1, 24'h000000);
    chk("relock_synced", 64'(synced_out), 64'h1);
    exp_q.push_back(48'hA5A5A55A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    idle(4);
    chk("relock_count", 64'(n_valid), 64'd6);
    chk("relock_audio", 64'(audio_out), 64'hA5A5A55A5A5A);

    // ws stuck low for 30 bits while locked
    start = bit_cnt;
    for (int i = 0; i < 30; i++) send_bit(1'b0, i[0]);
    idle(2);
    chk("stuck_err", 64'(n_err), 64'd2);
    chk("stuck_errpos", 64'(err_bits[$]), 64'(start + 24));
    chk("stuck_novalid", 64'(n_valid), 64'd6);
    chk("stuck_synced", 64'(synced_out), 64'h0);

    // Reset in the middle of a right word
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_word(1'b0, 24'h111111);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_audio", 64'(audio_out), 64'h0);
    chk("mrst_synced", 64'(synced_out), 64'h0);
    chk("mrst_valid", 64'(audio_valid_out), 64'h0);
    chk("mrst_error", 64'(frame_error_out), 64'h0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 13; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    idle(2);
    chk("mrst_nopartial", 64'(n_valid), 64'(v0));
    chk("mrst_noerr", 64'(n_err), 64'(e0));
    exp_q.push_back(48'hC0FFEE0BADF0);
    send_frame(24'hC0FFEE, 24'h0BADF0);
    idle(4);
    chk("mrst_count", 64'(n_valid), 64'(v0 + 1));
    chk("mrst_audio2", 64'(audio_out), 64'hC0FFEE0BADF0);

    // Minimum sck timing, random data
    hi = 1;
    lo = 1;
    v0 = n_valid;
    for (int i = 0; i < 8; i++) begin
      lw = 24'($urandom);
      rw = 24'($urandom);
      exp_q.push_back({lw, rw});
      send_frame(lw, rw);
    end
    idle(4);
    chk("fast_count", 64'(n_valid), 64'(v0 + 8));
    chk("fast_noerr", 64'(n_err), 64'(e0));
    chk("fast_synced", 64'(synced_out), 64'h1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
